ex_muldiv_seq: RTL and testbench

- Iterative RV32M multiply/divide sequencer attached to the execute stage.
- Accepts one M-extension op from EX and stalls the pipeline while it iterates.
- Returns a 32-bit result with a one-cycle done pulse, which EX muxes into its ALU/CSR result path.
- Shift-add multiply, restoring shift-subtract divide, with a single shared 64-bit working register.

---
 rtl/ex_muldiv_seq.sv | 178 +++++++++++++++++
 tb/tb_ex_muldiv_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the execute stage (shift-add MUL, restoring DIV).
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single cycle; divides always iterate.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for an M-op from EX; accepting one stalls the pipeline
// S_CALC | one multiply/divide iteration per cycle, 32 iterations
// S_DONE | result_o valid, done_o pulses, pipeline released

module ex_muldiv_seq #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_REM    = 3'd6;

   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN-1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     opb_q, opb_d;
   logic [2:0]          op_q, op_d;
   logic                neg_q, neg_d;
   logic                spec_q, spec_d;
   logic [XLEN-1:0]     res_q, res_d;

   logic                is_div_in, sgn1, sgn2, neg_in;
   logic                div_zero, div_ovf;
   logic [XLEN-1:0]     mag1, mag2, spec_res;

   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next;
   logic [XLEN:0]       div_rem, div_sub;
   logic                div_ge;
   logic [2*XLEN-1:0]   div_next;

   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     quo, rmd, final_res;

   // Operand preparation: magnitudes plus the sign of the eventual result
   always_comb begin
      is_div_in = op_i[2];
      sgn1      = ((op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                   (op_i == OP_DIV)  || (op_i == OP_REM)) && rs1_i[XLEN-1];
      sgn2      = ((op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM)) && rs2_i[XLEN-1];
      mag1      = sgn1 ? -rs1_i : rs1_i;
      mag2      = sgn2 ? -rs2_i : rs2_i;
      neg_in    = (op_i == OP_REM) ? sgn1 : (sgn1 ^ sgn2);
      div_zero  = is_div_in && (rs2_i == '0);
      div_ovf   = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                  (rs1_i == MIN_NEG) && (rs2_i == ALL_ONES);
      // op_i[1] selects the remainder flavour among the divide ops
      if (div_zero) spec_res = op_i[1] ? rs1_i : ALL_ONES;
      else          spec_res = op_i[1] ? '0 : MIN_NEG;
   end

   // Single iteration steps on the shared 64-bit working register
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
      mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
      div_rem  = acc_q[2*XLEN-1:XLEN-1];
      div_ge   = (div_rem >= {1'b0, opb_q});
      div_sub  = div_rem - {1'b0, opb_q};
      div_next = div_ge ? {div_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                        : {div_rem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
   end

   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rmd  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      if (spec_q)               final_res = acc_q[XLEN-1:0];
      else if (op_q == OP_MUL)  final_res = prod[XLEN-1:0];
      else if (!op_q[2])        final_res = prod[2*XLEN-1:XLEN];
      else if (op_q[1])         final_res = rmd;
      else                      final_res = quo;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opb_d   = opb_q;
      op_d    = op_q;
      neg_d   = neg_q;
      spec_d  = spec_q;
      res_d   = res_q;
      stall_o = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               stall_o = 1'b1;
               op_d    = op_i;
               neg_d   = neg_in;
               cnt_d   = '0;
               spec_d  = 1'b0;
               opb_d   = is_div_in ? mag2 : mag1;
               acc_d   = {{XLEN{1'b0}}, (is_div_in ? mag1 : mag2)};
               state_d = S_CALC;
               if (div_zero || div_ovf) begin
                  spec_d  = 1'b1;
                  acc_d   = {{XLEN{1'b0}}, spec_res};
                  state_d = S_DONE;
               end
`ifdef MULDIV_FAST_MUL_EN
               else if (!is_div_in) begin
                  acc_d   = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
                  state_d = S_DONE;
               end
`endif
            end
         end
         S_CALC: begin
            stall_o = 1'b1;
            acc_d   = op_q[2] ? div_next : mul_next;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_IT) state_d = S_DONE;
            if (flush_i)          state_d = S_IDLE;
         end
         S_DONE: begin
            done_o  = 1'b1;
            res_d   = final_res;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign result_o = (state_q == S_DONE) ? final_res : res_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         spec_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opb_q   <= opb_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         spec_q  <= spec_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Directed bench for ex_muldiv_seq: vector table plus flush, reset and double-start sequences.
// Build with MULDIV_FAST_MUL_EN defined to check the single-cycle multiply latency instead.

module tb_ex_muldiv_seq;

   logic        clk_i   = 1'b0;
   logic        rst_ni  = 1'b0;
   logic        start_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [2:0]  op_i    = '0;
   logic [31:0] rs1_i   = '0;
   logic [31:0] rs2_i   = '0;
   logic        stall_o, done_o;
   logic [31:0] result_o;

   int total = 0;
   int bad   = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   ex_muldiv_seq dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .start_i  (start_i),
      .op_i     (op_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .flush_i  (flush_i),
      .stall_o  (stall_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      bit          spec;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   // Caller is at #1 after a posedge; the start cycle is cycle 0.
   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int cyc;
      bit seen;
      op_i = op; rs1_i = a; rs2_i = b; start_i = 1'b1;
      @(negedge clk_i);
      chk({name, " stall_c0"}, 32'(stall_o), 32'd1);
      next_cycle();
      start_i = 1'b0;
      op_i    = 3'($urandom_range(0, 7));
      rs1_i   = $urandom;
      rs2_i   = $urandom;
      cyc  = 1;
      seen = 1'b0;
      while (cyc <= 40 && !seen) begin
         @(negedge clk_i);
         if (done_o) seen = 1'b1;
         else begin
            if (stall_o !== 1'b1) chk({name, " stall_busy"}, 32'(stall_o), 32'd1);
            next_cycle();
            cyc++;
         end
      end
      chk({name, " done_seen"}, 32'(seen), 32'd1);
      chk({name, " latency"}, 32'(cyc), 32'(lat));
      chk({name, " result"}, result_o, exp);
      chk({name, " stall_done"}, 32'(stall_o), 32'd0);
      next_cycle();
      @(negedge clk_i);
      chk({name, " done_pulse"}, 32'(done_o), 32'd0);
      chk({name, " result_hold"}, result_o, exp);
      next_cycle();
   endtask

   initial begin
      int dones, done_cyc;
      logic [31:0] done_res, prev;

      vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0}; // MUL 7*-3
      vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0}; // MULH
      vecs[2]  = '{3'd3, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0}; // MULHU
      vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0}; // MULHSU
      vecs[4]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0}; // MUL -1*-1
      vecs[5]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0}; // MULHU max
      vecs[6]  = '{3'd4, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFD, 1'b0}; // DIV -20/6
      vecs[7]  = '{3'd6, 32'hFFFFFFEC, 32'd6,        32'hFFFFFFFE, 1'b0}; // REM -20%6
      vecs[8]  = '{3'd5, 32'd100,      32'd7,        32'd14,       1'b0}; // DIVU
      vecs[9]  = '{3'd7, 32'd100,      32'd7,        32'd2,        1'b0}; // REMU
      vecs[10] = '{3'd4, 32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 1'b0}; // DIV 20/-6
      vecs[11] = '{3'd6, 32'd20,       32'hFFFFFFFA, 32'd2,        1'b0}; // REM 20%-6
      vecs[12] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1}; // DIVU /0
      vecs[13] = '{3'd7, 32'd5,        32'd0,        32'd5,        1'b1}; // REMU /0
      vecs[14] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1}; // DIV ovf
      vecs[15] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1}; // REM ovf
      vecs[16] = '{3'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b1}; // DIV /0
      vecs[17] = '{3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1}; // REM /0

      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("reset stall", 32'(stall_o), 32'd0);
      chk("reset done", 32'(done_o), 32'd0);
      chk("reset result", result_o, 32'd0);
      next_cycle();
      rst_ni = 1'b1;
      next_cycle();

      foreach (vecs[i]) begin
         int lat;
         if (vecs[i].spec)       lat = 1;
         else if (!vecs[i].op[2]) lat = MUL_LAT;
         else                    lat = 33;
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, lat);
      end

      // Flush at cycle 10 of a DIV: back to IDLE, no done, result untouched
      prev = 32'hFFFFFFF9;
      op_i = 3'd4; rs1_i = 32'hFFFFFFEC; rs2_i = 32'd6; start_i = 1'b1;
      next_cycle();
      start_i = 1'b0;
      dones = 0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk_i);
         if (done_o) dones++;
         next_cycle();
      end
      flush_i = 1'b1;
      @(negedge clk_i);
      if (done_o) dones++;
      next_cycle();
      flush_i = 1'b0;
      @(negedge clk_i);
      chk("flush stall_c11", 32'(stall_o), 32'd0);
      chk("flush no_done", 32'(dones + int'(done_o)), 32'd0);
      chk("flush result_kept", result_o, prev);
      next_cycle();
      run_op("after_flush DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 33);

      // Flush and start together in IDLE: not accepted
      op_i = 3'd5; rs1_i = 32'd5; rs2_i = 32'd0; start_i = 1'b1; flush_i = 1'b1;
      @(negedge clk_i);
      chk("flush_start stall", 32'(stall_o), 32'd0);
      next_cycle();
      start_i = 1'b0; flush_i = 1'b0;
      dones = 0;
      repeat (3) begin
         @(negedge clk_i);
         if (done_o) dones++;
         next_cycle();
      end
      chk("flush_start no_done", 32'(dones), 32'd0);
      chk("flush_start result", result_o, 32'd14);

      // Second start during CALC is ignored; exactly one done follows
      op_i = 3'd4; rs1_i = 32'hFFFFFFEC; rs2_i = 32'd6; start_i = 1'b1;
      next_cycle();
      start_i  = 1'b0;
      dones    = 0;
      done_cyc = 0;
      done_res = '0;
      for (int c = 1; c <= 50; c++) begin
         if (c == 5) begin
            op_i = 3'd0; rs1_i = 32'd7; rs2_i = 32'hFFFFFFFD; start_i = 1'b1;
         end else begin
            start_i = 1'b0;
         end
         @(negedge clk_i);
         if (done_o) begin
            dones++;
            done_cyc = c;
            done_res = result_o;
         end
         next_cycle();
      end
      chk("dbl_start done_count", 32'(dones), 32'd1);
      chk("dbl_start done_cycle", 32'(done_cyc), 32'd33);
      chk("dbl_start result", done_res, 32'hFFFFFFFD);

      // Asynchronous reset at cycle 15 of a MULHU
      op_i = 3'd3; rs1_i = 32'hFFFFFFFF; rs2_i = 32'hFFFFFFFF; start_i = 1'b1;
      next_cycle();
      start_i = 1'b0;
      repeat (14) next_cycle();
      rst_ni = 1'b0;
      #1;
      chk("rst_mid stall", 32'(stall_o), 32'd0);
      chk("rst_mid done", 32'(done_o), 32'd0);
      chk("rst_mid result", result_o, 32'd0);
      next_cycle();
      rst_ni = 1'b1;
      dones = 0;
      repeat (40) begin
         @(negedge clk_i);
         if (done_o) dones++;
         next_cycle();
      end
      chk("rst_mid no_done", 32'(dones), 32'd0);
      run_op("after_rst MULHU", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
